// File: rtl/round_timer_ctrl.sv
// Round countdown timer with pause/restart and a 30x30 digit-glyph ROM addresser.
// The counter runs in whole seconds of CLK_HZ cycles and shows the remaining count as a single digit.
module round_timer_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int START_SECS = 8,
  parameter int X0         = 565,
  parameter int Y0         = 410
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        logo,
  input  logic [8:0]  row,
  input  logic [9:0]  col,
  output logic [13:0] rom_addr,
  output logic        digit_en,
  output logic [3:0]  seconds_left,
  output logic        tick,
  output logic        done,
  output logic [1:0]  state
);

  localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [3:0]      LOAD       = 4'(START_SECS);
  localparam logic [13:0]     BOX_X      = 14'(X0);
  localparam logic [13:0]     BOX_Y      = 14'(Y0);
  localparam logic [13:0]     BOX_SIZE   = 14'd30;
  localparam logic [13:0]     GLYPH      = 14'd900;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t        cur_state, nxt_state;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    secs_n;
  logic          tick_n, done_n;

  logic [13:0]   row_x, col_x, glyph_base, pix_off, addr_n;
  logic          in_box;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= IDLE;
      presc        <= '0;
      seconds_left <= LOAD;
      tick         <= 1'b0;
      done         <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      presc        <= presc_n;
      seconds_left <= secs_n;
      tick         <= tick_n;
      done         <= done_n;
    end
  end

  // PAUSED with pause low behaves exactly like RUN, so a pause costs only the cycles it was held.
  always_comb begin
    nxt_state = cur_state;
    presc_n   = presc;
    secs_n    = seconds_left;
    tick_n    = 1'b0;
    done_n    = 1'b0;
    if (logo) begin
      nxt_state = IDLE;
      presc_n   = '0;
      secs_n    = LOAD;
    end else if (start) begin
      nxt_state = RUN;
      presc_n   = '0;
      secs_n    = LOAD;
    end else if (cur_state == RUN || cur_state == PAUSED) begin
      if (pause) begin
        nxt_state = PAUSED;
      end else if (presc == PRESC_LAST) begin
        presc_n = '0;
        if (seconds_left != 4'd0) begin
          secs_n = seconds_left - 4'd1;
          tick_n = 1'b1;
        end
        if (seconds_left <= 4'd1) begin
          nxt_state = DONE;
          done_n    = (seconds_left == 4'd1);
        end else begin
          nxt_state = RUN;
        end
      end else begin
        presc_n   = presc + PW'(1);
        nxt_state = RUN;
      end
    end else if (cur_state == DONE) begin
      presc_n = '0;
      secs_n  = 4'd0;
    end
  end

  assign state = cur_state;

  // Glyph address is pure arithmetic on row/col; the offset is only meaningful inside the box.
  always_comb begin
    row_x      = {5'd0, row};
    col_x      = {4'd0, col};
    in_box     = (row_x >= BOX_Y) && (row_x < BOX_Y + BOX_SIZE) &&
                 (col_x >= BOX_X) && (col_x < BOX_X + BOX_SIZE);
    glyph_base = {10'd0, seconds_left} * GLYPH;
    pix_off    = (row_x - BOX_Y) * BOX_SIZE + (col_x - BOX_X);
    addr_n     = in_box ? glyph_base + pix_off : glyph_base;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= 14'd0;
      digit_en <= 1'b0;
    end else begin
      rom_addr <= addr_n;
      digit_en <= in_box;
    end
  end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Self-checking bench for round_timer_ctrl at CLK_HZ=10, START_SECS=3.
// Every step drives inputs, queues the expected post-edge outputs, and compares them one edge later.
module tb_round_timer_ctrl;

  localparam int CLK_HZ     = 10;
  localparam int START_SECS = 3;
  localparam int X0         = 565;
  localparam int Y0         = 410;

  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSED = 2;
  localparam int S_DONE   = 3;

  logic        clk = 1'b0;
  logic        reset, start, pause, logo;
  logic [8:0]  row;
  logic [9:0]  col;
  logic [13:0] rom_addr;
  logic        digit_en;
  logic [3:0]  seconds_left;
  logic        tick, done;
  logic [1:0]  state;

  round_timer_ctrl #(
    .CLK_HZ(CLK_HZ), .START_SECS(START_SECS), .X0(X0), .Y0(Y0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .logo(logo),
    .row(row), .col(col), .rom_addr(rom_addr), .digit_en(digit_en),
    .seconds_left(seconds_left), .tick(tick), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        reset, start, pause, logo;
    logic [8:0]  row;
    logic [9:0]  col;
    logic [1:0]  e_state;
    logic [3:0]  e_secs;
    logic        e_tick, e_done, e_en;
    logic [13:0] e_addr;
    string       name;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[9];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input string nm, input int rst, input int st, input int ps,
                              input int lg, input int r, input int c, input int es,
                              input int esec, input int et, input int ed, input int ee,
                              input int ea);
    vec_t v;
    v.name    = nm;
    v.reset   = (rst != 0);
    v.start   = (st != 0);
    v.pause   = (ps != 0);
    v.logo    = (lg != 0);
    v.row     = 9'(r);
    v.col     = 10'(c);
    v.e_state = 2'(es);
    v.e_secs  = 4'(esec);
    v.e_tick  = (et != 0);
    v.e_done  = (ed != 0);
    v.e_en    = (ee != 0);
    v.e_addr  = 14'(ea);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset = v.reset;
    start = v.start;
    pause = v.pause;
    logo  = v.logo;
    row   = v.row;
    col   = v.col;
    sb.push_back(v);
  endtask

  task automatic cmp(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty got=0 want=1");
      return;
    end
    e = sb.pop_front();
    cmp({e.name, ".state"},    int'(state),        int'(e.e_state));
    cmp({e.name, ".secs"},     int'(seconds_left), int'(e.e_secs));
    cmp({e.name, ".tick"},     int'(tick),         int'(e.e_tick));
    cmp({e.name, ".done"},     int'(done),         int'(e.e_done));
    cmp({e.name, ".digit_en"}, int'(digit_en),     int'(e.e_en));
    cmp({e.name, ".rom_addr"}, int'(rom_addr),     int'(e.e_addr));
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int sb_secs, sa_secs, r, c, es;

    // reset beats start; then pixel box boundaries at seconds_left=3; logo beats start
    tbl[0] = mk("reset0",   1, 1, 0, 0, 410, 565, S_IDLE, 3, 0, 0, 0, 0);
    tbl[1] = mk("pix_tl",   0, 0, 0, 0, 410, 565, S_IDLE, 3, 0, 0, 1, 2700);
    tbl[2] = mk("pix_br",   0, 0, 0, 0, 439, 594, S_IDLE, 3, 0, 0, 1, 3599);
    tbl[3] = mk("pix_above",0, 0, 0, 0, 409, 565, S_IDLE, 3, 0, 0, 0, 2700);
    tbl[4] = mk("pix_right",0, 0, 0, 0, 410, 595, S_IDLE, 3, 0, 0, 0, 2700);
    tbl[5] = mk("pix_below",0, 0, 0, 0, 440, 570, S_IDLE, 3, 0, 0, 0, 2700);
    tbl[6] = mk("pix_left", 0, 0, 0, 0, 420, 564, S_IDLE, 3, 0, 0, 0, 2700);
    tbl[7] = mk("logo_st",  0, 1, 0, 1, 0,   0,   S_IDLE, 3, 0, 0, 0, 2700);
    tbl[8] = mk("logo_hold",0, 0, 0, 1, 0,   0,   S_IDLE, 3, 0, 0, 0, 2700);

    for (int i = 0; i < 9; i++) step(tbl[i]);

    // full round with in-box pixels sweeping while the count drops
    step(mk("start0", 0, 1, 0, 0, 0, 0, S_RUN, 3, 0, 0, 0, 2700));
    for (int k = 1; k <= 30; k++) begin
      sb_secs = 3 - (k - 1) / 10;
      sa_secs = 3 - k / 10;
      r  = Y0 + (k % 30);
      c  = X0 + ((k * 7) % 30);
      es = (k == 30) ? S_DONE : S_RUN;
      step(mk($sformatf("round%0d", k), 0, 0, 0, 0, r, c, es, sa_secs,
              (k % 10 == 0) ? 1 : 0, (k == 30) ? 1 : 0, 1,
              sb_secs * 900 + (k % 30) * 30 + (k * 7) % 30));
    end
    for (int j = 0; j < 3; j++)
      step(mk($sformatf("done_hold%0d", j), 0, 0, j % 2, 0, 0, 0, S_DONE, 0, 0, 0, 0, 0));

    // restart from DONE, first tick ten cycles later
    step(mk("restart", 0, 1, 0, 0, 0, 0, S_RUN, 3, 0, 0, 0, 0));
    for (int k = 1; k <= 10; k++)
      step(mk($sformatf("rs%0d", k), 0, 0, 0, 0, 0, 0, S_RUN, (k == 10) ? 2 : 3,
              (k == 10) ? 1 : 0, 0, 0, 2700));

    // pause held five cycles at prescaler=4 delays the tick by five
    for (int k = 11; k <= 14; k++)
      step(mk($sformatf("rs%0d", k), 0, 0, 0, 0, 0, 0, S_RUN, 2, 0, 0, 0, 1800));
    for (int k = 15; k <= 19; k++)
      step(mk($sformatf("pz%0d", k), 0, 0, 1, 0, 0, 0, S_PAUSED, 2, 0, 0, 0, 1800));
    for (int k = 20; k <= 25; k++)
      step(mk($sformatf("rs%0d", k), 0, 0, 0, 0, 0, 0, S_RUN, (k == 25) ? 1 : 2,
              (k == 25) ? 1 : 0, 0, 0, 1800));

    // pause arriving exactly on the wrap cycle suppresses the tick
    for (int k = 26; k <= 34; k++)
      step(mk($sformatf("rs%0d", k), 0, 0, 0, 0, 0, 0, S_RUN, 1, 0, 0, 0, 900));
    step(mk("race_pause", 0, 0, 1, 0, 0, 0, S_PAUSED, 1, 0, 0, 0, 900));
    step(mk("race_resume", 0, 0, 0, 0, 0, 0, S_DONE, 0, 1, 1, 0, 900));

    // start ignores pause; logo at prescaler=9 wins over start with no tick
    step(mk("lstart", 0, 1, 1, 0, 0, 0, S_RUN, 3, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++)
      step(mk($sformatf("lr%0d", k), 0, 0, 0, 0, 0, 0, S_RUN, 3, 0, 0, 0, 2700));
    step(mk("logo_run", 0, 1, 0, 1, 0, 0, S_IDLE, 3, 0, 0, 0, 2700));
    step(mk("logo_h1",  0, 0, 1, 1, 0, 0, S_IDLE, 3, 0, 0, 0, 2700));
    step(mk("logo_h2",  0, 1, 0, 1, 0, 0, S_IDLE, 3, 0, 0, 0, 2700));
    step(mk("idle_stay",0, 0, 0, 0, 0, 0, S_IDLE, 3, 0, 0, 0, 2700));

    // reset mid-round at prescaler=9 overrides start and pause
    step(mk("rstart", 0, 1, 0, 0, 0, 0, S_RUN, 3, 0, 0, 0, 2700));
    for (int k = 1; k <= 9; k++)
      step(mk($sformatf("rr%0d", k), 0, 0, 0, 0, 0, 0, S_RUN, 3, 0, 0, 0, 2700));
    step(mk("rst_run",  1, 1, 1, 0, 410, 565, S_IDLE, 3, 0, 0, 0, 0));
    step(mk("post_rst", 0, 0, 0, 0, 0,   0,   S_IDLE, 3, 0, 0, 0, 2700));

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
